bcd_to_binary: RTL and testbench

Multi-cycle converter that turns a packed BCD value back into straight binary using reverse double-dabble: shift right, then subtract 3 from every BCD digit that reads 8 or more. It is the return path for the binary-to-BCD display chain. Counter and keypad values held as BCD digits are converted to binary here for arithmetic and compare logic. One iteration runs per clock, controlled by a start/busy/done handshake.

---
 rtl/bcd_conv_pkg.sv | 15 +
 rtl/bcd_digit_adjust.sv | 12 +
 rtl/bcd_to_binary.sv | 107 ++++++++++
 tb/tb_bcd_to_binary.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/bcd_conv_pkg.sv
// Shared constants and state encoding for the BCD-to-binary converter.
// Nibble thresholds follow reverse double-dabble: after a right shift, a digit reading 8+ is corrected by 3.
package bcd_conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] ADJ_THRESH = 4'd8;
  localparam logic [3:0] ADJ_SUB    = 4'd3;
  localparam logic [3:0] BCD_MAX    = 4'd9;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Per-digit correction for reverse double-dabble: a shifted nibble of 8 or more loses 3.
// Purely combinational; digits never borrow from one another.
module bcd_digit_adjust
  import bcd_conv_pkg::*;
(
  input  logic [3:0] nibble_in,
  output logic [3:0] nibble_out
);

  assign nibble_out = (nibble_in >= ADJ_THRESH) ? (nibble_in - ADJ_SUB) : nibble_in;

endmodule

// File: rtl/bcd_to_binary.sv
// Multi-cycle packed-BCD to binary converter, one reverse double-dabble iteration per clock.
// Handshake: start sampled in IDLE, busy during the shift phase, one-cycle done with bin/err.
module bcd_to_binary
  import bcd_conv_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin,
  output logic                  err
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  state_t              state;
  logic [WORK_W-1:0]   work;
  logic [WORK_W-1:0]   shifted;
  logic [WORK_W-1:0]   adjusted;
  logic [CNT_W-1:0]    cnt;
  logic                bad;
  logic [DIGITS-1:0]   nib_bad;
  logic                in_bad;

  assign shifted = work >> 1;
  assign adjusted[BIN_W-1:0] = shifted[BIN_W-1:0];

  // The BCD field sits above the binary field, so digit g starts at BIN_W + 4*g.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adjust
    bcd_digit_adjust u_adj (
      .nibble_in  (shifted[BIN_W + 4*g +: 4]),
      .nibble_out (adjusted[BIN_W + 4*g +: 4])
    );
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_check
    assign nib_bad[g] = (bcd[4*g +: 4] > BCD_MAX);
  end

  assign in_bad = |nib_bad;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the work register is a plain flop vector, so it is reset along with the rest of the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      work  <= '0;
      cnt   <= '0;
      bad   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      bin   <= '0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work <= {bcd, {BIN_W{1'b0}}};
            cnt  <= '0;
            bad  <= in_bad;
            if (in_bad) begin
              state <= DONE;
            end else begin
              state <= SHIFT;
              busy  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          work <= adjusted;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            state <= DONE;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          done  <= 1'b1;
          bin   <= bad ? '0 : work[BIN_W-1:0];
          err   <= bad;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  // A valid conversion must drain every BCD digit into the binary field.
  always @(posedge clk) begin
    if (rst && state == DONE && !bad) begin
      assert (work[WORK_W-1:BIN_W] == '0)
        else $error("bcd_to_binary: residual BCD field %0h after conversion", work[WORK_W-1:BIN_W]);
    end
  end
`endif

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed bench for bcd_to_binary: reset, corner values, invalid digits, ignored start, mid-run reset.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_bcd_to_binary;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;

  logic              clk;
  logic              rst;
  logic              start;
  logic [15:0]       bcd;
  logic              busy;
  logic              done;
  logic [BIN_W-1:0]  bin;
  logic              err;

  int checks;
  int failures;

  bcd_to_binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bcd   (bcd),
    .busy  (busy),
    .done  (done),
    .bin   (bin),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launches one conversion, then counts cycles to done and cycles with busy high.
  task automatic run_conv(input string tag, input logic [15:0] value,
                          input int exp_bin, input bit exp_err,
                          input int exp_lat, input int exp_busy);
    int n;
    int busy_cnt;
    start = 1'b1;
    bcd   = value;
    tick();
    start = 1'b0;
    bcd   = 16'hFFFF;
    n        = 0;
    busy_cnt = 0;
    while (!done && n < 40) begin
      if (busy) busy_cnt++;
      tick();
      n++;
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    check({tag, "_bin"}, bin, exp_bin);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_busy_at_done"}, busy, 0);
  endtask

  initial begin
    int dones;
    checks   = 0;
    failures = 0;

    rst   = 1'b0;
    start = 1'b1;
    bcd   = 16'h1234;
    repeat (3) tick();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_bin", bin, 0);
    check("reset_err", err, 0);

    start = 1'b0;
    rst   = 1'b1;
    repeat (4) tick();
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);

    run_conv("basic_1234", 16'h1234, 1234, 1'b0, 15, 14);
    check("done_one_cycle", done, 1);
    run_conv("zero", 16'h0000, 0, 1'b0, 15, 14);
    run_conv("max_9999", 16'h9999, 9999, 1'b0, 15, 14);
    run_conv("eight", 16'h0008, 8, 1'b0, 15, 14);
    run_conv("hundred", 16'h0100, 100, 1'b0, 15, 14);

    run_conv("invalid", 16'h12A4, 0, 1'b1, 1, 0);
    run_conv("after_invalid", 16'h0042, 42, 1'b0, 15, 14);
    tick();
    check("done_drops", done, 0);

    // Second start mid-conversion must be ignored and not queued.
    start = 1'b1;
    bcd   = 16'h0777;
    tick();
    start = 1'b0;
    bcd   = 16'h0000;
    repeat (4) tick();
    start = 1'b1;
    bcd   = 16'h5555;
    tick();
    start = 1'b0;
    bcd   = 16'h0000;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        dones++;
        check("busy_start_bin", bin, 777);
        check("busy_start_err", err, 0);
      end
      tick();
    end
    check("busy_start_dones", dones, 1);
    check("busy_start_idle", busy, 0);
    check("busy_start_final_bin", bin, 777);

    // Reset in the middle of a conversion clears outputs at once and suppresses done.
    start = 1'b1;
    bcd   = 16'h4321;
    tick();
    start = 1'b0;
    repeat (6) tick();
    check("mid_busy_before", busy, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_bin", bin, 0);
    check("mid_rst_err", err, 0);
    repeat (2) tick();
    rst = 1'b1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) dones++;
      tick();
    end
    check("mid_rst_no_done", dones, 0);
    run_conv("after_rst_0010", 16'h0010, 10, 1'b0, 15, 14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
